// File: rtl/serial_word_rx.sv
// Serial word receiver. Each enabled edge samples one frame bit: start, WIDTH data bits LSB first, [parity], stop.
// The assembled word is offered through a valid/ready holding register. Build with SERIAL_WORD_RX_PARITY_EN to add an even-parity bit.
//
// state    | meaning
// S_IDLE   | line idle, waiting for a 0 start bit
// S_DATA   | shifting in WIDTH data bits, LSB first
// S_PARITY | sampling the parity bit (parity builds only)
// S_STOP   | sampling the stop bit, then deliver or flag an error
module serial_word_rx #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             D,
    input  logic             en,
    input  logic             ready,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun,
    output logic             parity_err
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
`ifdef SERIAL_WORD_RX_PARITY_EN
        S_PARITY = 2'd2,
`endif
        S_STOP   = 2'd3
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0] r_shreg, w_shreg_nxt;
    logic [WIDTH-1:0] r_data, w_data_nxt;
    logic             r_valid, w_valid_nxt;
    logic             r_ferr, w_ferr_nxt;
    logic             r_ovr, w_ovr_nxt;
    logic             w_slot_free;
    logic             w_word_ok;
`ifdef SERIAL_WORD_RX_PARITY_EN
    logic             r_par, w_par_nxt;
    logic             r_perr, w_perr_nxt;
`endif

    // A slot is free if it is empty or being drained on this very edge.
    assign w_slot_free = !r_valid || ready;
`ifdef SERIAL_WORD_RX_PARITY_EN
    assign w_word_ok   = (r_par == ^r_shreg);
`else
    assign w_word_ok   = 1'b1;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shreg_nxt = r_shreg;
        w_data_nxt  = r_data;
        w_valid_nxt = r_valid;
        w_ferr_nxt  = 1'b0;
        w_ovr_nxt   = 1'b0;
`ifdef SERIAL_WORD_RX_PARITY_EN
        w_par_nxt   = r_par;
        w_perr_nxt  = 1'b0;
`endif
        if (r_valid && ready) begin
            w_valid_nxt = 1'b0;
        end
        if (en) begin
            case (r_state)
                S_IDLE: begin
                    if (!D) begin
                        w_state_nxt = S_DATA;
                        w_cnt_nxt   = '0;
                    end
                end
                S_DATA: begin
                    w_shreg_nxt = {D, r_shreg[WIDTH-1:1]};
                    if (r_cnt == CNT_LAST) begin
                        w_cnt_nxt = '0;
`ifdef SERIAL_WORD_RX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end
                end
`ifdef SERIAL_WORD_RX_PARITY_EN
                S_PARITY: begin
                    w_par_nxt   = D;
                    w_state_nxt = S_STOP;
                end
`endif
                S_STOP: begin
                    w_state_nxt = S_IDLE;
                    if (!D) begin
                        w_ferr_nxt = 1'b1;
                    end else if (!w_word_ok) begin
`ifdef SERIAL_WORD_RX_PARITY_EN
                        w_perr_nxt = 1'b1;
`endif
                    end else if (w_slot_free) begin
                        w_data_nxt  = r_shreg;
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_ovr_nxt = 1'b1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_shreg <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
`ifdef SERIAL_WORD_RX_PARITY_EN
            r_par   <= 1'b0;
            r_perr  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_shreg <= w_shreg_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_ferr  <= w_ferr_nxt;
            r_ovr   <= w_ovr_nxt;
`ifdef SERIAL_WORD_RX_PARITY_EN
            r_par   <= w_par_nxt;
            r_perr  <= w_perr_nxt;
`endif
        end
    end

    assign data_out  = r_data;
    assign valid     = r_valid;
    assign busy      = (r_state != S_IDLE);
    assign frame_err = r_ferr;
    assign overrun   = r_ovr;
`ifdef SERIAL_WORD_RX_PARITY_EN
    assign parity_err = r_perr;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_rx.sv
// Bench for serial_word_rx: directed frames plus random frames checked every cycle against a frame-level model.
// Follows SERIAL_WORD_RX_PARITY_EN the same way the design does.
module tb_serial_word_rx;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         resetn;
    logic         D;
    logic         en;
    logic         ready;
    logic [W-1:0] data_out;
    logic         valid;
    logic         busy;
    logic         frame_err;
    logic         overrun;
    logic         parity_err;

    int checks   = 0;
    int failures = 0;

    // Model of what the consumer should see.
    logic [W-1:0] m_data;
    logic         m_valid;
    logic         m_busy;
    logic         m_ferr, m_ovr, m_perr;

    serial_word_rx #(.WIDTH(W)) dut (
        .clk(clk), .resetn(resetn), .D(D), .en(en), .ready(ready),
        .data_out(data_out), .valid(valid), .busy(busy),
        .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all();
        chk("valid",      {31'd0, valid},      {31'd0, m_valid});
        chk("data_out",   {16'd0, data_out},   {16'd0, m_data});
        chk("busy",       {31'd0, busy},       {31'd0, m_busy});
        chk("frame_err",  {31'd0, frame_err},  {31'd0, m_ferr});
        chk("overrun",    {31'd0, overrun},    {31'd0, m_ovr});
        chk("parity_err", {31'd0, parity_err}, {31'd0, m_perr});
    endtask

    task automatic model_reset();
        m_data = '0; m_valid = 1'b0; m_busy = 1'b0;
        m_ferr = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
    endtask

    // One clock: drive inputs, take the edge, advance the model, compare.
    task automatic step(input logic d, input logic e, input logic r,
                        input bit is_start, input bit is_stop,
                        input logic [W-1:0] word, input bit par_ok);
        bit free;
        D = d; en = e; ready = r;
        @(posedge clk);
        #1;
        m_ferr = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
        free = !m_valid || r;
        if (m_valid && r) m_valid = 1'b0;
        if (e && is_start) m_busy = 1'b1;
        if (e && is_stop) begin
            m_busy = 1'b0;
            if (!d)          m_ferr = 1'b1;
            else if (!par_ok) m_perr = 1'b1;
            else if (free) begin
                m_data = word; m_valid = 1'b1;
            end else         m_ovr = 1'b1;
        end
        chk_all();
    endtask

    function automatic logic pick_ready(input int mode);
        if (mode == 0) return 1'b1;
        if (mode == 1) return 1'b0;
        return 1'($urandom_range(0, 1));
    endfunction

    // en_mode: 0 continuous, 1 two idle strobes between bits, 2 random gaps.
    // ready_mode: 0 always 1, 1 always 0, 2 random.
    task automatic send_frame(input logic [W-1:0] word, input logic stop_bit,
                              input bit par_flip, input int en_mode, input int ready_mode);
        logic bits[$];
        bit   par_ok;
        int   gaps;
        par_ok = 1'b1;
        bits.push_back(1'b0);
        for (int i = 0; i < W; i++) bits.push_back(word[i]);
`ifdef SERIAL_WORD_RX_PARITY_EN
        bits.push_back((^word) ^ par_flip);
        par_ok = !par_flip;
`else
        if (par_flip) par_ok = 1'b1;
`endif
        bits.push_back(stop_bit);
        for (int i = 0; i < bits.size(); i++) begin
            gaps = (en_mode == 0 || i == 0) ? 0 : (en_mode == 1) ? 2 : $urandom_range(0, 2);
            for (int g = 0; g < gaps; g++)
                step(1'($urandom_range(0, 1)), 1'b0, pick_ready(ready_mode), 0, 0, word, par_ok);
            step(bits[i], 1'b1, pick_ready(ready_mode), i == 0, i == bits.size() - 1, word, par_ok);
        end
    endtask

    task automatic idle(input int n, input int ready_mode);
        for (int i = 0; i < n; i++)
            step(1'b1, 1'($urandom_range(0, 1)), pick_ready(ready_mode), 0, 0, '0, 1'b1);
    endtask

    initial begin
        resetn = 1'b0; D = 1'b1; en = 1'b0; ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all();
        resetn = 1'b1;
        idle(2, 0);

        // Clean frame, continuous en, ready high.
        send_frame(16'hA5C3, 1'b1, 0, 0, 0);
        chk("a5c3_data", {16'd0, data_out}, 32'h0000A5C3);
        idle(2, 0);
        chk("a5c3_valid_drop", {31'd0, valid}, 32'd0);

        // Stop bit 0 after reset.
        resetn = 1'b0; #1; model_reset(); resetn = 1'b1;
        send_frame(16'hA5C3, 1'b0, 0, 0, 0);
        chk("ferr_data_kept_zero", {16'd0, data_out}, 32'd0);
        idle(2, 0);

        // Back-to-back with consumer stalled, then drain.
        send_frame(16'h1234, 1'b1, 0, 0, 1);
        send_frame(16'hBEEF, 1'b1, 0, 0, 1);
        chk("overrun_data_kept", {16'd0, data_out}, 32'h00001234);
        step(1'b1, 1'b1, 1'b1, 0, 0, '0, 1'b1);
        chk("drained", {31'd0, valid}, 32'd0);
        idle(1, 0);

        // Gapped enable.
        send_frame(16'h00FF, 1'b1, 0, 1, 0);
        chk("gapped_data", {16'd0, data_out}, 32'h000000FF);
        idle(2, 0);

        // Abort a frame with reset after 7 data bits.
        send_frame(16'h5555, 1'b1, 0, 0, 1);
        step(1'b0, 1'b1, 1'b0, 1, 0, '0, 1'b1);
        for (int i = 0; i < 7; i++) step(1'($urandom_range(0, 1)), 1'b1, 1'b0, 0, 0, '0, 1'b1);
        #2 resetn = 1'b0;
        #1 model_reset();
        chk_all();
        @(posedge clk); #1;
        resetn = 1'b1;
        chk_all();
        send_frame(16'h8001, 1'b1, 0, 0, 0);
        chk("after_abort", {16'd0, data_out}, 32'h00008001);
        idle(2, 0);

`ifdef SERIAL_WORD_RX_PARITY_EN
        send_frame(16'h0001, 1'b1, 1, 0, 0);
        idle(1, 0);
        send_frame(16'h0001, 1'b1, 0, 0, 0);
        chk("parity_good", {16'd0, data_out}, 32'h00000001);
        idle(2, 0);
`endif

        // Random traffic.
        for (int f = 0; f < 40; f++) begin
            send_frame(W'($urandom), ($urandom_range(0, 5) != 0), ($urandom_range(0, 4) == 0),
                       $urandom_range(0, 2), $urandom_range(0, 2));
            idle($urandom_range(0, 2), 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_word_rx.md
Name: serial_word_rx

Overview:
- Receiving end of a clocked single-bit serial link that loads 16-bit words into the CPU datapath.
- Each enabled clock samples one bit of the frame: start bit, WIDTH data bits LSB first, optional parity bit, stop bit.
- The assembled word goes to the consumer through a valid/ready holding register.
- Serial pattern generators and benches drive its D input.

Parameters:
WIDTH, 16, data bits per frame; also width of data_out.

Ports:
clk  input  1  system clock; all state changes on rising edge
resetn  input  1  asynchronous active-low reset
D  input  1  serial data in; idles high
en  input  1  bit-sample strobe; D is sampled only on edges where en=1
ready  input  1  consumer accepts data_out when valid=1
data_out  output  WIDTH  received word; stable while valid=1
valid  output  1  data_out holds an unconsumed word
busy  output  1  frame in progress (state != IDLE)
frame_err  output  1  one-cycle pulse: stop bit sampled as 0
overrun  output  1  one-cycle pulse: completed word dropped because holding register occupied
parity_err  output  1  one-cycle pulse: parity mismatch (tied 0 when parity compiled out)

Behaviour:
- Reset (resetn=0, asynchronous):
  - state=IDLE, shift register=0, bit counter=0.
  - data_out=0, valid=0, busy=0, all error pulses 0.
  - Reset mid-frame discards the partial frame. A valid word is also discarded.
- States: IDLE, DATA, PARITY (present only with macro), STOP.
- en=0 edges: no state, counter or shift change in any state. Handshake logic still runs.
- IDLE:
  - en=1 and D=0 -> DATA; bit counter=0.
  - en=1 and D=1 -> stay in IDLE.
- DATA:
  - On each en=1 edge: shift register <= {D, shreg[WIDTH-1:1]}, so the first data bit ends in bit 0.
  - Counter increments. On the edge sampling bit WIDTH-1 -> PARITY if the macro is defined, else STOP. Counter returns to 0.
- PARITY: on en=1, latch the sampled bit -> STOP.
- STOP, on en=1, always -> IDLE:
  - D=0: frame_err=1 for one cycle; word dropped.
  - D=1 with a parity mismatch: parity_err=1 for one cycle; word dropped.
  - D=1 with parity OK or parity absent: the word is delivered if the slot is free. Slot free = (valid=0) or (ready=1) at that edge. Delivery sets data_out<=shreg and valid<=1 on that same edge.
  - D=1, word good, slot not free: overrun=1 for one cycle; data_out and valid unchanged; new word dropped.
  - frame_err takes priority over parity_err. Only one error pulse can fire per frame.
- Handshake:
  - valid=1 and ready=1 at an edge -> valid<=0, unless a delivery occurs on that same edge. In that case valid stays 1 with the new data and there is no overrun.
  - ready with valid=0 is ignored.
  - data_out only changes on delivery.
- Latency: valid is asserted on the clock edge that samples the stop bit. No additional pipeline stage.
- Framing: no resynchronisation or glitch filter. A start bit is any D=0 sampled in IDLE. The next start can be sampled on the first en=1 edge after STOP.
- busy is a combinational decode of state: 1 in DATA/PARITY/STOP.

Optional Feature:
- Macro: SERIAL_WORD_RX_PARITY_EN.
- Defined:
  - PARITY state present; frame length WIDTH+3 bits.
  - Expected bit = XOR of all data bits (even parity). A mismatch drops the word and pulses parity_err, subject to the STOP rules.
- Undefined:
  - PARITY state and logic absent; frame length WIDTH+2 bits.
  - parity_err tied 0; port list unchanged.

Test Plan:
- Reset, en=1 every cycle, ready=1. Send start 0, data 16'hA5C3 LSB first, stop 1 -> after the stop-bit edge data_out=16'hA5C3 and valid=1 for exactly one cycle. No error pulses.
- Same frame with stop bit 0 -> frame_err pulses once; valid stays 0; data_out stays 0; busy returns to 0.
- ready=0. Send 16'h1234, then 16'hBEEF back-to-back -> first word valid=1, data_out=16'h1234. At the second stop edge overrun pulses and data_out stays 16'h1234. Then ready=1 for one cycle -> valid=0.
- en toggling 1,0,0,1,... during frame 16'h00FF -> result identical to the continuous-en case: data_out=16'h00FF. State frozen during en=0 cycles.
- Pull resetn low after 7 data bits, release, then send 16'h8001 -> valid only for 16'h8001. No spurious valid or error from the aborted frame.
- With macro: 16'h0001 followed by parity bit 0 -> parity_err pulses and valid=0. The same word with parity bit 1 -> valid=1, data_out=16'h0001.
